// File: rtl/audio_post.sv
// Stereo post-processor: decimates the DAC stream, mixes, boosts, low-pass
// filters and saturates to 16 bits through one shared datapath.
//
// state  | meaning
// IDLE   | wait for sample strobe, capture inputs and config
// MIX    | compute stereo-mixed (and boosted) yl/yr
// FILT_L | left accumulator update on shared adder
// FILT_R | right accumulator update on shared adder
// OUT    | saturate, present sample, pulse aud_valid
module audio_post #(
  parameter int DIV = 598
) (
  input  logic        clk,
  input  logic        _rst,
  input  logic [14:0] ldata,
  input  logic [14:0] rdata,
  input  logic [1:0]  mix,
  input  logic        boost,
  input  logic        flt_en,
  input  logic [3:0]  flt_k,
  input  logic        clip_clr,
  output logic [15:0] aud_l,
  output logic [15:0] aud_r,
  output logic        aud_valid,
  output logic        clip
);

  typedef enum logic [2:0] {IDLE, MIX, FILT_L, FILT_R, OUT} state_t;

  localparam logic [15:0] LAST = 16'(DIV - 1);

  state_t state, state_n;
  logic [15:0] cnt;
  logic strobe;

  logic signed [15:0] xl, xr;
  logic [1:0] mix_s;
  logic boost_s, flt_en_s;
  logic [3:0] flt_k_s;
  logic signed [17:0] yl, yr;
  logic signed [25:0] acc_l, acc_r;

  logic signed [17:0] y_sel;
  logic signed [25:0] acc_sel, acc_nxt, step;
  logic signed [26:0] diff;
  logic [16:0] sat_l, sat_r;

  function automatic logic signed [17:0] mix_calc(input logic signed [17:0] a,
                                                  input logic signed [17:0] b,
                                                  input logic [1:0] m,
                                                  input logic bst);
    logic signed [17:0] r;
    case (m)
      2'd0:    r = a;
      2'd1:    r = a - (a >>> 2) + (b >>> 2);
      2'd2:    r = a - (a >>> 2) - (a >>> 3) + (b >>> 2) + (b >>> 3);
      default: r = (a >>> 1) + (b >>> 1);
    endcase
    return bst ? (r <<< 1) : r;
  endfunction

  // Returns {clamped, value} for the integer part of an accumulator.
  function automatic logic [16:0] sat16(input logic signed [17:0] q);
    if (q > 18'sd32767)
      return {1'b1, 16'h7fff};
    else if (q < -18'sd32768)
      return {1'b1, 16'h8000};
    else
      return {1'b0, q[15:0]};
  endfunction

  assign strobe = (cnt == LAST);

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) cnt <= '0;
    else       cnt <= strobe ? 16'd0 : cnt + 16'd1;
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (strobe) state_n = MIX;
      MIX:     state_n = FILT_L;
      FILT_L:  state_n = FILT_R;
      FILT_R:  state_n = OUT;
      OUT:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Shared filter adder: right channel only in FILT_R, left otherwise.
  always_comb begin
    y_sel   = (state == FILT_R) ? yr : yl;
    acc_sel = (state == FILT_R) ? acc_r : acc_l;
    diff    = {y_sel[17], y_sel, 8'b0} - {acc_sel[25], acc_sel};
    step    = 26'(diff >>> flt_k_s);
    acc_nxt = flt_en_s ? (acc_sel + step) : {y_sel, 8'b0};
  end

  assign sat_l = sat16(acc_l[25:8]);
  assign sat_r = sat16(acc_r[25:8]);

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      xl        <= '0;
      xr        <= '0;
      mix_s     <= '0;
      boost_s   <= 1'b0;
      flt_en_s  <= 1'b0;
      flt_k_s   <= '0;
      yl        <= '0;
      yr        <= '0;
      acc_l     <= '0;
      acc_r     <= '0;
      aud_l     <= '0;
      aud_r     <= '0;
      aud_valid <= 1'b0;
      clip      <= 1'b0;
    end else begin
      aud_valid <= 1'b0;
      clip      <= clip & ~clip_clr;
      case (state)
        IDLE: if (strobe) begin
          xl       <= {ldata, 1'b0};
          xr       <= {rdata, 1'b0};
          mix_s    <= mix;
          boost_s  <= boost;
          flt_en_s <= flt_en;
          flt_k_s  <= flt_k;
        end
        MIX: begin
          yl <= mix_calc({{2{xl[15]}}, xl}, {{2{xr[15]}}, xr}, mix_s, boost_s);
          yr <= mix_calc({{2{xr[15]}}, xr}, {{2{xl[15]}}, xl}, mix_s, boost_s);
        end
        FILT_L: acc_l <= acc_nxt;
        FILT_R: acc_r <= acc_nxt;
        OUT: begin
          aud_l     <= sat_l[15:0];
          aud_r     <= sat_r[15:0];
          aud_valid <= 1'b1;
          // A new clamp wins over a simultaneous clear.
          clip      <= sat_l[16] | sat_r[16] | (clip & ~clip_clr);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_post.sv
// Bench for audio_post: directed spec cases plus randomized samples checked
// against an integer-arithmetic reference of the mixing/filter rules.
module tb_audio_post;
  localparam int DIV = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [14:0] ldata, rdata;
  logic [1:0]  mix;
  logic        boost, flt_en, clip_clr;
  logic [3:0]  flt_k;
  logic [15:0] aud_l, aud_r;
  logic        aud_valid, clip;

  int checks = 0;
  int errors = 0;

  longint m_acc_l, m_acc_r;
  bit     m_clip;
  int     exp_n;
  int     e_l, e_r;

  audio_post #(.DIV(DIV)) dut (
    .clk(clk), ._rst(rst_n), .ldata(ldata), .rdata(rdata), .mix(mix),
    .boost(boost), .flt_en(flt_en), .flt_k(flt_k), .clip_clr(clip_clr),
    .aud_l(aud_l), .aud_r(aud_r), .aud_valid(aud_valid), .clip(clip)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int mix_ref(input int a, input int b, input int m, input bit bst);
    int r;
    case (m)
      0:       r = a;
      1:       r = a - (a >>> 2) + (b >>> 2);
      2:       r = a - (a >>> 2) - (a >>> 3) + (b >>> 2) + (b >>> 3);
      default: r = (a >>> 1) + (b >>> 1);
    endcase
    return bst ? r * 2 : r;
  endfunction

  function automatic longint filt_ref(input longint acc, input int y, input bit fen, input int k);
    longint t = longint'(y) * 256;
    return fen ? acc + ((t - acc) >>> k) : t;
  endfunction

  function automatic int clamp16(input longint v, output bit c);
    c = 1'b1;
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    c = 1'b0;
    return int'(v);
  endfunction

  task automatic model_reset();
    m_acc_l = 0; m_acc_r = 0; m_clip = 1'b0; exp_n = DIV + 4;
  endtask

  task automatic run_sample(input logic [14:0] ld, input logic [14:0] rd,
                            input logic [1:0] m, input logic b, input logic fen,
                            input logic [3:0] k, input bit clr);
    int xl, xr, n;
    bit cl, cr, got;
    ldata = ld; rdata = rd; mix = m; boost = b; flt_en = fen; flt_k = k;
    xl = 2 * int'($signed(ld));
    xr = 2 * int'($signed(rd));
    m_acc_l = filt_ref(m_acc_l, mix_ref(xl, xr, m, b), fen, k);
    m_acc_r = filt_ref(m_acc_r, mix_ref(xr, xl, m, b), fen, k);
    e_l = clamp16(m_acc_l >>> 8, cl);
    e_r = clamp16(m_acc_r >>> 8, cr);
    m_clip = cl | cr | (m_clip & !clr);
    n = 0; got = 1'b0;
    while (!got && n < exp_n + 8) begin
      @(negedge clk); n++;
      if (n == exp_n - 4) begin
        // inputs are already captured: disturbing them must not matter
        ldata = 15'($urandom); rdata = 15'($urandom); mix = 2'($urandom);
        boost = 1'($urandom); flt_en = 1'($urandom); flt_k = 4'($urandom);
      end
      if (n == exp_n - 1 && clr) clip_clr = 1'b1;
      if (n == exp_n) clip_clr = 1'b0;
      if (aud_valid) got = 1'b1;
    end
    clip_clr = 1'b0;
    chk("valid_time", got ? n : -1, exp_n);
    chk("aud_l", $signed(aud_l), e_l);
    chk("aud_r", $signed(aud_r), e_r);
    chk("clip", clip, m_clip);
    @(negedge clk);
    chk("valid_pulse", aud_valid, 0);
    exp_n = DIV - 1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_aud_l", aud_l, 0);
    chk("rst_aud_r", aud_r, 0);
    chk("rst_valid", aud_valid, 0);
    chk("rst_clip", clip, 0);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int flt_exp[5] = '{8000, 12000, 14000, 15000, 15500};
    bit vseen;
    if (DIV < 6) begin
      $display("FAIL div_param observed=%0d expected>=6", DIV);
      $fatal(1);
    end
    rst_n = 1'b0; clip_clr = 1'b0;
    ldata = 15'h1555; rdata = 15'h2aaa; mix = 2'd2; boost = 1'b1;
    flt_en = 1'b1; flt_k = 4'd3;
    @(negedge clk);
    do_reset();

    // Passthrough
    run_sample(15'h1234, 15'h7fff, 2'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    chk("pass_l", $signed(aud_l), 32'sh2468);
    chk("pass_r", $signed(aud_r), -2);
    chk("pass_clip", clip, 0);

    // Mono cancels opposite signals
    run_sample(15'd1000, -15'sd1000, 2'd3, 1'b0, 1'b0, 4'd0, 1'b0);
    chk("mono_l", $signed(aud_l), 0);
    chk("mono_r", $signed(aud_r), 0);

    // 3/4 + 1/4 mix
    run_sample(15'd4000, 15'd0, 2'd1, 1'b0, 1'b0, 4'd0, 1'b0);
    chk("mix1_l", $signed(aud_l), 6000);
    chk("mix1_r", $signed(aud_r), 2000);

    // Filter step response from reset
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_sample(15'd8000, 15'd0, 2'd0, 1'b0, 1'b1, 4'd1, 1'b0);
      chk("flt_step", $signed(aud_l), flt_exp[i]);
    end
    run_sample(15'd8000, 15'd0, 2'd0, 1'b0, 1'b0, 4'd1, 1'b0);
    chk("flt_off", $signed(aud_l), 16000);
    for (int i = 0; i < 2; i++) begin
      run_sample(15'd8000, 15'd0, 2'd0, 1'b0, 1'b1, 4'd1, 1'b0);
      chk("flt_reenable", $signed(aud_l), 16000);
    end

    // Saturation and sticky clip
    run_sample(15'd12000, -15'sd12000, 2'd0, 1'b1, 1'b0, 4'd0, 1'b0);
    chk("sat_l", $signed(aud_l), 32767);
    chk("sat_r", $signed(aud_r), -32768);
    chk("sat_clip", clip, 1);
    run_sample(15'd12000, -15'sd12000, 2'd0, 1'b1, 1'b0, 4'd0, 1'b1);
    chk("clip_set_wins", clip, 1);
    run_sample(15'd100, 15'd100, 2'd0, 1'b0, 1'b0, 4'd0, 1'b1);
    chk("clip_cleared", clip, 0);
    run_sample(15'd12000, -15'sd12000, 2'd0, 1'b1, 1'b0, 4'd0, 1'b0);
    chk("clip_reset_pre", clip, 1);

    // Reset during FILT_L of a clamping sample
    ldata = 15'd12000; rdata = -15'sd12000; mix = 2'd0; boost = 1'b1; flt_en = 1'b0;
    repeat (exp_n - 3) @(negedge clk);
    rst_n = 1'b0;
    vseen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (aud_valid) vseen = 1'b1;
    end
    chk("midrst_valid", vseen, 0);
    chk("midrst_l", aud_l, 0);
    chk("midrst_r", aud_r, 0);
    chk("midrst_clip", clip, 0);
    rst_n = 1'b1;
    model_reset();

    // Randomized samples against the reference
    for (int i = 0; i < 40; i++)
      run_sample(15'($urandom), 15'($urandom), 2'($urandom), 1'($urandom),
                 1'($urandom), 4'($urandom), ($urandom_range(3) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/audio_post.md
# audio_post

Stereo audio post-processor between the minimig core's 15-bit DAC outputs (`ldata`/`rdata`) and the 16-bit signed `AUDIO_L`/`AUDIO_R` outputs of `emu`. It decimates the 28 MHz-domain sample stream to a fixed output rate using an internal strobe counter. A small shared-datapath FSM applies stereo-separation mixing, optional boost and a one-pole low-pass ("LED filter"). It then saturates to 16 bits and presents a registered sample with a one-cycle valid pulse.

## Interface
Parameters:
- `DIV`, default 598: sample-strobe period in `clk` cycles (28.6875 MHz / 598 ≈ 48 kHz); legal range 6..65535.

Ports:
- `clk` in 1: system clock (`clk_28`).
- `_rst` in 1: reset. Asynchronous assert, active-low.
- `ldata` in 15: left input sample, two's complement.
- `rdata` in 15: right input sample, two's complement.
- `mix` in 2: stereo separation. 0 = full stereo, 1 = 3/4 own + 1/4 other, 2 = 5/8 own + 3/8 other, 3 = mono.
- `boost` in 1: ×2 gain before the filter.
- `flt_en` in 1: low-pass enable.
- `flt_k` in 4: filter shift coefficient, 0..15.
- `clip_clr` in 1: clears `clip`.
- `aud_l` out 16: left output, signed.
- `aud_r` out 16: right output, signed.
- `aud_valid` out 1: one-cycle pulse when `aud_l`/`aud_r` update.
- `clip` out 1: sticky saturation flag.

## Operation
Strobe counter:
- `cnt` counts 0..DIV-1 and wraps.
- Strobe fires on the cycle where `cnt == DIV-1`.

Capture at strobe:
- `xl = {ldata,1'b0}` and `xr = {rdata,1'b0}`, both 16-bit signed.
- `mix`, `boost`, `flt_en` and `flt_k` are captured into shadow registers in the same cycle; these shadow values apply for the whole sample.

FSM states: IDLE → MIX → FILT_L → FILT_R → OUT → IDLE. Each state lasts one cycle; IDLE waits for the strobe.

- **MIX** (18-bit signed intermediates, `>>>` is arithmetic/floor):
  - mix 0: `yl = xl`.
  - mix 1: `yl = xl - (xl>>>2) + (xr>>>2)`.
  - mix 2: `yl = xl - (xl>>>2) - (xl>>>3) + (xr>>>2) + (xr>>>3)`.
  - mix 3: `yl = (xl>>>1) + (xr>>>1)`.
  - `yr` is symmetric (swap `xl`/`xr`).
  - If `boost`, then `y = y <<< 1`.
- **FILT_L / FILT_R**: one shared adder/shifter, left channel first, then right.
  - Per-channel accumulator `acc`: 26-bit signed, 8 fractional bits.
  - `flt_en = 1`: `acc ← acc + (((y <<< 8) - acc) >>> flt_k)`.
  - `flt_en = 0`: `acc ← y <<< 8`. The accumulator keeps tracking, so enabling the filter causes no step.
  - `flt_k = 0` is therefore an exact passthrough.
- **OUT**:
  - `aud_l`/`aud_r` ← `sat16(acc >>> 8)`, clamped to [-32768, 32767].
  - `aud_valid` is high for this cycle only.
  - `clip` is set if either channel clamped.
- **`clip`**: sticky. Cleared by `clip_clr`; if set and clear occur in the same cycle, set wins.
- **Strobe while FSM busy**: cannot occur, since `DIV ≥ 6`. The bench asserts this via a parameter check.

## Timing
Reset values (asynchronous on `_rst` low):
- `aud_l = aud_r = 0`, `aud_valid = 0`, `clip = 0`.
- Both accumulators 0, `cnt = 0`, FSM in IDLE, shadow registers 0.

After reset:
- The first strobe occurs on the DIV-th rising edge after `_rst` deasserts.

Latency:
- Inputs are sampled on strobe edge T.
- Outputs change, and `aud_valid` is high, on edge T+4.
- Outputs then hold until the next OUT state.
- `aud_valid` period is exactly DIV cycles.

Reset asserted mid-sequence:
- The FSM aborts immediately and all state returns to reset values.
- No partial sample is emitted.

Input changes:
- Changes to `ldata`/`rdata`/config between strobes have no effect on outputs.

## Test plan
1. **Reset/startup.**
   - Stimulus: hold `_rst` low with nonzero inputs, then release.
   - Required: outputs 0 and `aud_valid` 0 while in reset; first `aud_valid` exactly DIV+4 edges after release; subsequent pulses every DIV cycles.
2. **Passthrough.**
   - Stimulus: `mix=0`, `flt_en=0`, `boost=0`, `ldata=15'h1234`, `rdata=15'h7FFF` (-1).
   - Required: `aud_l=16'h2468`, `aud_r=16'hFFFE`, `clip=0`.
3. **Mixing, mix=3.**
   - Stimulus: `ldata=1000`, `rdata=-1000`.
   - Required: `aud_l=aud_r=0`.
4. **Mixing, mix=1.**
   - Stimulus: `ldata=4000`, `rdata=0`.
   - Required: `aud_l=6000`, `aud_r=2000`.
5. **Filter step.**
   - Stimulus: from reset, `flt_en=1`, `flt_k=1`, `ldata` stepped to 8000 (`xl=16000`).
   - Required: successive `aud_l` = 8000, 12000, 14000, 15000, 15500.
   - Then set `flt_en=0`: next `aud_l=16000`.
   - Then set `flt_en=1` with a constant input: output stays 16000 with no step.
6. **Saturation, clip and reset mid-operation.**
   - Stimulus: `boost=1`, `ldata=12000`, `rdata=-12000`.
   - Required: `aud_l=32767`, `aud_r=-32768`, `clip=1`.
   - Pulse `clip_clr` on the same cycle as a clamping OUT: `clip` stays 1.
   - Pulse `_rst` low during FILT_L: no `aud_valid`, outputs 0, `clip` 0.
